// File: rtl/triple_repeat_tx_if.sv
// Handshake bundle for the 3x repetition transmitter: word input side
// (in_val/in_rdy/in_data) and chip output side (out_val/out_rdy/out_bit/out_last).
//
// Handshake rule for both sides: a transfer happens on a posedge where
// val and rdy are both high; val-side data must stay stable until that edge.
interface triple_repeat_tx_if #(
  parameter int NBITS = 4
) ();
  logic             in_val;
  logic             in_rdy;
  logic [NBITS-1:0] in_data;
  logic             out_val;
  logic             out_rdy;
  logic             out_bit;
  logic             out_last;

  // Transmitter side: takes words, drives chips.
  modport slave (
    input  in_val,
    input  in_data,
    input  out_rdy,
    output in_rdy,
    output out_val,
    output out_bit,
    output out_last
  );

  // Producer/channel side: offers words, consumes chips.
  modport master (
    output in_val,
    output in_data,
    output out_rdy,
    input  in_rdy,
    input  out_val,
    input  out_bit,
    input  out_last
  );
endinterface

// File: rtl/triple_repeat_tx.sv
// Transmit side of the 3x repetition link. A word accepted on the input
// handshake is sent LSB first, each bit repeated as three consecutive chips.
// Outputs depend only on registered state (and rst for in_rdy), so there is
// no combinational path from the input handshake to the chip stream.
module triple_repeat_tx #(
  parameter int NBITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  triple_repeat_tx_if.slave   bus,
  output logic                state_dbg
);

  // bidx needs at least one bit even when NBITS=1 (it is then a constant 0).
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(NBITS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [NBITS-1:0] sreg, sreg_nxt;
  logic [BW-1:0]    bidx, bidx_nxt;
  logic [1:0]       rep, rep_nxt;

  logic in_rdy_w;
  logic out_val_w;
  logic out_bit_w;
  logic out_last_w;
  logic accept;
  logic chip_xfer;

  // Handshake outputs, derived from state only.
  always_comb begin
    in_rdy_w   = (state == IDLE) && !rst;
    out_val_w  = (state == SEND);
    out_bit_w  = out_val_w && sreg[0];
    out_last_w = out_val_w && (bidx == LAST_IDX) && (rep == 2'd2);
    accept     = bus.in_val && in_rdy_w;
    chip_xfer  = out_val_w && bus.out_rdy;
  end

  assign bus.in_rdy   = in_rdy_w;
  assign bus.out_val  = out_val_w;
  assign bus.out_bit  = out_bit_w;
  assign bus.out_last = out_last_w;
  assign state_dbg    = state;

  // Next-state logic: load a word in IDLE, step rep/bidx on each chip transfer.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    bidx_nxt  = bidx;
    rep_nxt   = rep;
    case (state)
      IDLE: begin
        if (accept) begin
          sreg_nxt  = bus.in_data;
          bidx_nxt  = '0;
          rep_nxt   = 2'd0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (chip_xfer) begin
          if (rep != 2'd2) begin
            rep_nxt = rep + 2'd1;
          end else if (bidx != LAST_IDX) begin
            rep_nxt  = 2'd0;
            bidx_nxt = bidx + BW'(1);
            sreg_nxt = sreg >> 1;
          end else begin
            // Final chip consumed; rdy stays low this cycle so a new word
            // can only be taken after at least one IDLE cycle.
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset abandons any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      bidx  <= '0;
      rep   <= 2'd0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      bidx  <= bidx_nxt;
      rep   <= rep_nxt;
    end
  end

endmodule

// File: tb/tb_triple_repeat_tx.sv
// Directed bench for triple_repeat_tx: reset, plain word, stalled word,
// busy-time input changes, mid-word reset, and an NBITS=1 instance.
module tb_triple_repeat_tx;

  logic clk;
  logic rst;
  logic state_dbg;
  logic state_dbg1;

  triple_repeat_tx_if #(.NBITS(4)) bus ();
  triple_repeat_tx_if #(.NBITS(1)) bus1 ();

  triple_repeat_tx #(.NBITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  triple_repeat_tx #(.NBITS(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus1),
    .state_dbg (state_dbg1)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Chips listed first-chip-in-MSB, hand-computed from the data word.
  task automatic push_chips(input logic [11:0] chips);
    for (int i = 11; i >= 0; i--) exp_q.push_back(chips[i]);
  endtask

  // ---------------- drivers ----------------
  // Wait (bounded) for in_rdy, present the word for one accept edge.
  task automatic offer(input logic [3:0] d, input bit hold);
    int g;
    g = 0;
    @(negedge clk);
    while (!bus.in_rdy && g < 20) begin
      @(negedge clk);
      g++;
    end
    check_eq("offer_rdy", bus.in_rdy, 1);
    bus.in_val  = 1'b1;
    bus.in_data = d;
    @(posedge clk);
    #1;
    if (!hold) bus.in_val = 1'b0;
  endtask

  // Consume n_take chips of an n_total-chip word, optionally stalling
  // stall_len cycles while chip index stall_at is presented.
  task automatic drain(input int n_total, input int n_take, input int stall_at,
                       input int stall_len, output int cycles);
    int taken;
    int stalled;
    int guard;
    logic e;
    taken   = 0;
    stalled = 0;
    guard   = 0;
    cycles  = 0;
    while (taken < n_take && guard < 200) begin
      @(negedge clk);
      guard++;
      if (bus.out_val) begin
        cycles++;
        check_eq("busy_in_rdy", bus.in_rdy, 0);
        if (taken == stall_at && stalled < stall_len) begin
          bus.out_rdy = 1'b0;
          stalled++;
          check_eq($sformatf("stall_bit%0d", taken), bus.out_bit, exp_q[0]);
          check_eq($sformatf("stall_last%0d", taken), bus.out_last, 0);
        end else begin
          bus.out_rdy = 1'b1;
          e = exp_q.pop_front();
          check_eq($sformatf("chip%0d", taken), bus.out_bit, e);
          check_eq($sformatf("last%0d", taken), bus.out_last, (taken == n_total - 1));
          taken++;
        end
      end
    end
    check_eq("chip_count", taken, n_take);
  endtask

  // After a complete word: exactly one cycle later the block is IDLE again.
  task automatic check_idle(input string tag);
    @(negedge clk);
    check_eq({tag, "_out_val"}, bus.out_val, 0);
    check_eq({tag, "_in_rdy"}, bus.in_rdy, 1);
    check_eq({tag, "_state"}, state_dbg, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    rst          = 1'b1;
    bus.in_val   = 1'b0;
    bus.in_data  = '0;
    bus.out_rdy  = 1'b1;
    bus1.in_val  = 1'b0;
    bus1.in_data = '0;
    bus1.out_rdy = 1'b1;

    // 1: reset held two cycles
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_in_rdy", bus.in_rdy, 0);
      check_eq("rst_out_val", bus.out_val, 0);
      check_eq("rst_out_bit", bus.out_bit, 0);
      check_eq("rst_out_last", bus.out_last, 0);
      check_eq("rst_state", state_dbg, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_rdy", bus.in_rdy, 1);
    check_eq("post_rst_out_val", bus.out_val, 0);

    // 2: 4'b1011 with no backpressure
    push_chips(12'b111_111_000_111);
    offer(4'b1011, 1'b0);
    drain(12, 12, -1, 0, cyc);
    check_eq("plain_send_cycles", cyc, 12);
    check_idle("plain_end");

    // 3: same word, chip 5 stalled three cycles
    push_chips(12'b111_111_000_111);
    offer(4'b1011, 1'b0);
    drain(12, 12, 4, 3, cyc);
    check_eq("stall_send_cycles", cyc, 15);
    check_idle("stall_end");

    // 4: in_val held with in_data wandering while busy
    push_chips(12'b111_111_000_111);
    offer(4'b1011, 1'b1);
    fork
      begin
        drain(12, 12, -1, 0, cyc);
        check_idle("busy_end");
      end
      begin
        int g;
        g = 0;
        while (g < 100) begin
          @(negedge clk);
          g++;
          if (bus.in_rdy) begin
            bus.in_data = 4'b0110;
            @(posedge clk);
            #1;
            bus.in_val = 1'b0;
            break;
          end else begin
            bus.in_data = 4'($urandom_range(0, 15));
          end
        end
      end
    join
    push_chips(12'b000_111_111_000);
    drain(12, 12, -1, 0, cyc);
    check_eq("second_send_cycles", cyc, 12);
    check_idle("second_end");

    // 5: reset at chip 7 of 4'b0110, then 4'b0001
    push_chips(12'b000_111_111_000);
    offer(4'b0110, 1'b0);
    drain(12, 6, -1, 0, cyc);
    @(negedge clk);
    check_eq("chip7_val", bus.out_val, 1);
    check_eq("chip7_bit", bus.out_bit, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_out_val", bus.out_val, 0);
    check_eq("abort_in_rdy", bus.in_rdy, 0);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_eq("abort_idle_rdy", bus.in_rdy, 1);
    check_eq("abort_idle_val", bus.out_val, 0);
    push_chips(12'b111_000_000_000);
    offer(4'b0001, 1'b0);
    drain(12, 12, -1, 0, cyc);
    check_idle("after_abort_end");

    // 6: NBITS=1 instance, data 1
    @(negedge clk);
    check_eq("n1_in_rdy", bus1.in_rdy, 1);
    bus1.in_val  = 1'b1;
    bus1.in_data = 1'b1;
    @(posedge clk);
    #1;
    bus1.in_val = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("n1_val%0d", k), bus1.out_val, 1);
      check_eq($sformatf("n1_bit%0d", k), bus1.out_bit, 1);
      check_eq($sformatf("n1_last%0d", k), bus1.out_last, (k == 2));
      check_eq($sformatf("n1_in_rdy%0d", k), bus1.in_rdy, 0);
    end
    @(negedge clk);
    check_eq("n1_end_val", bus1.out_val, 0);
    check_eq("n1_end_rdy", bus1.in_rdy, 1);
    check_eq("n1_end_state", state_dbg1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
